// File: rtl/bsg_profiler_pkg.sv
// Shared types and helpers for the interval profiler.
// Holds the measurement FSM state encoding, the default-width sample record,
// and the bucket quantisation function used by the bucketizer.
package bsg_profiler_pkg;

    // Default widths for the sample record (match the meter's default parameters)
    localparam int unsigned profiler_width_lp        = 16;
    localparam int unsigned profiler_bucket_width_lp = 4;

    // Widest latency / bucket index the quantisation function can handle
    localparam int unsigned profiler_max_width_lp        = 64;
    localparam int unsigned profiler_max_bucket_width_lp = 32;

    // Measurement FSM states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        TIMING = 1'b1
    } profiler_state_e;

    // One buffered sample: bucket index and raw latency
    typedef struct packed {
        logic [profiler_bucket_width_lp-1:0] bucket;
        logic [profiler_width_lp-1:0]        latency;
    } profiler_sample_s;

    // Quantise a latency into a bucket index.
    // Linear mode: min(latency >> shift, 2^bucket_width - 1).
    // Log2 mode:   min(floor(log2(latency >> shift)), 2^bucket_width - 1),
    //              with a shifted latency of 0 landing in bucket 0.
    // The log2 path is a priority encoder: the highest set bit wins because
    // the loop visits bits in ascending order and the last hit overwrites.
    function automatic logic [profiler_max_bucket_width_lp-1:0] profiler_bucket_f(
        input logic [profiler_max_width_lp-1:0] latency,
        input int unsigned                      shift,
        input int unsigned                      bucket_width,
        input logic                             log2_en
    );
        logic [profiler_max_width_lp-1:0]        shifted;
        logic [profiler_max_bucket_width_lp-1:0] maxBucket;
        logic [profiler_max_bucket_width_lp-1:0] raw;
        shifted   = latency >> shift;
        maxBucket = (32'd1 << bucket_width) - 32'd1;
        raw       = '0;
        if (log2_en) begin
            for (int i = 0; i < profiler_max_width_lp; i++) begin
                if (shifted[i]) begin
                    raw = 32'(i);
                end
            end
        end else begin
            if (shifted > {32'd0, maxBucket}) begin
                raw = maxBucket;
            end else begin
                raw = shifted[profiler_max_bucket_width_lp-1:0];
            end
        end
        return (raw > maxBucket) ? maxBucket : raw;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with valid/ready on the write side and valid/yumi on
// the read side. A write is also accepted while full if the head is being
// taken in the same cycle, so a full FIFO can stream at full rate.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptrWidthLp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int countWidthLp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptrWidthLp-1:0]   rdPtr_q, rdPtr_d;
    logic [ptrWidthLp-1:0]   wrPtr_q, wrPtr_d;
    logic [countWidthLp-1:0] count_q, count_d;
    logic                    enq;
    logic                    deq;

    function automatic logic [ptrWidthLp-1:0] nextPtr(input logic [ptrWidthLp-1:0] ptr);
        return (ptr == ptrWidthLp'(els_p - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign v_o     = (count_q != '0);
    assign ready_o = (count_q != countWidthLp'(els_p));
    assign deq     = yumi_i & v_o;
    assign enq     = v_i & (ready_o | deq);
    assign data_o  = mem_q[rdPtr_q];

    // Advance pointers and occupancy for this cycle's enqueue/dequeue
    always_comb begin
        rdPtr_d = deq ? nextPtr(rdPtr_q) : rdPtr_q;
        wrPtr_d = enq ? nextPtr(wrPtr_q) : wrPtr_q;
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful under the occupancy count
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_profiler_interval_bucketize.sv
// Combinational latency quantiser for the interval profiler.
// Build option: define BSG_PROFILER_INTERVAL_LOG2_BIN_EN to switch from
// linear bins to log2 bins; the port list is the same either way.
module bsg_profiler_interval_bucketize
    import bsg_profiler_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int bucket_width_p = 4,
    parameter int shift_p        = 0
) (
    input  logic [width_p-1:0]        latency_i,
    output logic [bucket_width_p-1:0] bucket_o
);

`ifdef BSG_PROFILER_INTERVAL_LOG2_BIN_EN
    localparam logic log2EnLp = 1'b1;
`else
    localparam logic log2EnLp = 1'b0;
`endif

    logic [profiler_max_bucket_width_lp-1:0] bucketIdx;
    logic                                    unusedIdxBits;

    // Quantise the latency; only the low bucket_width_p bits can be non-zero
    always_comb begin
        bucketIdx = profiler_bucket_f(64'(latency_i), shift_p, bucket_width_p, log2EnLp);
    end

    assign bucket_o      = bucketIdx[bucket_width_p-1:0];
    assign unusedIdxBits = ^bucketIdx[profiler_max_bucket_width_lp-1:bucket_width_p];

endmodule

// File: rtl/bsg_profiler_interval_meter.sv
// Single-outstanding start-to-end latency meter feeding a histogram client.
// Each measured interval becomes a {bucket, latency} sample on a valid/yumi
// stream. Build option: BSG_PROFILER_INTERVAL_LOG2_BIN_EN selects log2 bins.
module bsg_profiler_interval_meter
    import bsg_profiler_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int bucket_width_p = 4,
    parameter int shift_p        = 0,
    parameter int els_p          = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_v_i,
    input  logic                      end_v_i,
    output logic                      v_o,
    output logic [bucket_width_p-1:0] bucket_o,
    output logic [width_p-1:0]        latency_o,
    input  logic                      yumi_i,
    output logic                      busy_o,
    output logic [width_p-1:0]        drop_count_o
);

    localparam int sampleWidthLp = bucket_width_p + width_p;

    profiler_state_e            state_q, state_d;
    logic [width_p-1:0]         counter_q, counter_d;
    logic [width_p-1:0]         dropCount_q, dropCount_d;
    logic [sampleWidthLp-1:0]   lastSample_q;
    logic [bucket_width_p-1:0]  bucket;
    logic                       sampleV;
    logic                       fifoReady;
    logic                       fifoV;
    logic [sampleWidthLp-1:0]   fifoData;
    logic                       dropSample;

    // State and latency counter registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next state: start arms the counter at 1, end closes the interval,
    // start+end while timing closes one interval and arms the next
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    state_d   = TIMING;
                    counter_d = width_p'(1);
                end
            end
            TIMING: begin
                if (end_v_i) begin
                    if (start_v_i) begin
                        counter_d = width_p'(1);
                    end else begin
                        state_d   = IDLE;
                        counter_d = '0;
                    end
                end else if (start_v_i) begin
                    counter_d = width_p'(1);
                end else if (counter_q != '1) begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase
    end

    // Outputs of the FSM: busy flag and the sample strobe at the end event
    always_comb begin
        busy_o  = (state_q == TIMING);
        sampleV = (state_q == TIMING) && end_v_i;
    end

    bsg_profiler_interval_bucketize #(
        .width_p        (width_p),
        .bucket_width_p (bucket_width_p),
        .shift_p        (shift_p)
    ) bucketize (
        .latency_i (counter_q),
        .bucket_o  (bucket)
    );

    bsg_fifo_1r1w_small #(
        .width_p (sampleWidthLp),
        .els_p   (els_p)
    ) sampleFifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (sampleV),
        .ready_o (fifoReady),
        .data_i  ({bucket, counter_q}),
        .v_o     (fifoV),
        .data_o  (fifoData),
        .yumi_i  (yumi_i)
    );

    // A sample is lost only when the buffer is full and nothing leaves this cycle
    always_comb begin
        dropSample  = sampleV && !fifoReady && !yumi_i;
        dropCount_d = dropCount_q;
        if (dropSample && (dropCount_q != '1)) begin
            dropCount_d = dropCount_q + 1'b1;
        end
    end

    // Drop counter and the last-presented sample, so outputs hold once drained
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dropCount_q  <= '0;
            lastSample_q <= '0;
        end else begin
            dropCount_q <= dropCount_d;
            if (fifoV) begin
                lastSample_q <= fifoData;
            end
        end
    end

    assign v_o          = fifoV;
    assign bucket_o     = fifoV ? fifoData[sampleWidthLp-1:width_p] : lastSample_q[sampleWidthLp-1:width_p];
    assign latency_o    = fifoV ? fifoData[width_p-1:0] : lastSample_q[width_p-1:0];
    assign drop_count_o = dropCount_q;

endmodule

// File: tb/tb_bsg_profiler_interval_meter.sv
// Directed self-checking bench for bsg_profiler_interval_meter with default
// parameters (width 16, bucket width 4, shift 0, two buffer entries).
// Expected buckets follow BSG_PROFILER_INTERVAL_LOG2_BIN_EN when defined.
module tb_bsg_profiler_interval_meter;

`ifdef BSG_PROFILER_INTERVAL_LOG2_BIN_EN
    localparam int expB2  = 1;
    localparam int expB3  = 1;
    localparam int expB4  = 2;
    localparam int expB5  = 2;
    localparam int expB7  = 2;
    localparam int expB40 = 5;
`else
    localparam int expB2  = 2;
    localparam int expB3  = 3;
    localparam int expB4  = 4;
    localparam int expB5  = 5;
    localparam int expB7  = 7;
    localparam int expB40 = 15;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        startV;
    logic        endV;
    logic        yumiReq;
    logic        autoYumi;
    logic        yumi;
    logic        vO;
    logic [3:0]  bucketO;
    logic [15:0] latencyO;
    logic        busyO;
    logic [15:0] dropCountO;

    int assertCount = 0;
    int failCount   = 0;

    // Free-running clock, period 10
    always #5 clock = ~clock;

    // Consumer: explicit pulses, or take every sample as soon as it shows
    assign yumi = yumiReq | (autoYumi & vO);

    bsg_profiler_interval_meter #(
        .width_p        (16),
        .bucket_width_p (4),
        .shift_p        (0),
        .els_p          (2)
    ) dut (
        .clk_i        (clock),
        .reset_i      (reset),
        .start_v_i    (startV),
        .end_v_i      (endV),
        .v_o          (vO),
        .bucket_o     (bucketO),
        .latency_o    (latencyO),
        .yumi_i       (yumi),
        .busy_o       (busyO),
        .drop_count_o (dropCountO)
    );

    // Consumer must never take from an empty buffer
    always @(posedge clock) begin
        if (!reset) begin
            assertCount++;
            assert (!(yumi && !vO)) else begin
                failCount++;
                $error("[TB] FAIL yumiProtocol: observed yumi=%0b with v_o=%0b, required v_o=1", yumi, vO);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Hold inputs across exactly one rising edge, then return to quiet
    task automatic applyStimulus(input logic s, input logic e, input logic y);
        startV  = s;
        endV    = e;
        yumiReq = y;
        @(negedge clock);
        startV  = 1'b0;
        endV    = 1'b0;
        yumiReq = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        startV   = 1'b0;
        endV     = 1'b0;
        yumiReq  = 1'b0;
        autoYumi = 1'b0;
        idleCycles(2);
        checkOutput("resetValid",   32'(vO),         0);
        checkOutput("resetBucket",  32'(bucketO),    0);
        checkOutput("resetLatency", 32'(latencyO),   0);
        checkOutput("resetBusy",    32'(busyO),      0);
        checkOutput("resetDrops",   32'(dropCountO), 0);
        reset = 1'b0;
        idleCycles(2);

        // Interval of 5 with an always-ready consumer
        autoYumi = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("l5BusyAfterStart", 32'(busyO), 1);
        idleCycles(4);
        checkOutput("l5BusyBeforeEnd", 32'(busyO), 1);
        checkOutput("l5NoSampleYet",   32'(vO),    0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("l5Valid",   32'(vO),       1);
        checkOutput("l5Latency", 32'(latencyO), 5);
        checkOutput("l5Bucket",  32'(bucketO),  expB5);
        checkOutput("l5BusyEnd", 32'(busyO),    0);
        idleCycles(1);
        checkOutput("l5Drained",     32'(vO),       0);
        checkOutput("l5HoldLatency", 32'(latencyO), 5);
        checkOutput("l5HoldBucket",  32'(bucketO),  expB5);
        autoYumi = 1'b0;
        idleCycles(1);

        // Interval of 40: clamps in linear mode
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(39);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("l40Valid",   32'(vO),       1);
        checkOutput("l40Latency", 32'(latencyO), 40);
        checkOutput("l40Bucket",  32'(bucketO),  expB40);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("l40Drained", 32'(vO), 0);

        // Four intervals of 3 into a two-entry buffer with no consumer
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            idleCycles(2);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("fullValid",   32'(vO),         1);
        checkOutput("fullLatency", 32'(latencyO),   3);
        checkOutput("fullBucket",  32'(bucketO),    expB3);
        checkOutput("fullDrops",   32'(dropCountO), 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fullPop1Valid",   32'(vO),       1);
        checkOutput("fullPop1Latency", 32'(latencyO), 3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fullPop2Valid", 32'(vO),         0);
        checkOutput("fullDropsKept", 32'(dropCountO), 2);

        // Back-to-back re-arm: start+end at 7, then end 4 cycles later
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rearmBusy",    32'(busyO),    1);
        checkOutput("rearmValid",   32'(vO),       1);
        checkOutput("rearmLatency", 32'(latencyO), 7);
        checkOutput("rearmBucket",  32'(bucketO),  expB7);
        idleCycles(3);
        checkOutput("rearmBusyMid", 32'(busyO), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rearmBusyEnd",  32'(busyO),    0);
        checkOutput("rearmHeadKept", 32'(latencyO), 7);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rearm2Valid",   32'(vO),       1);
        checkOutput("rearm2Latency", 32'(latencyO), 4);
        checkOutput("rearm2Bucket",  32'(bucketO),  expB4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rearmDrained", 32'(vO), 0);

        // End alone in IDLE is ignored; start+end in IDLE only starts timing
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("idleEndBusy",  32'(busyO), 0);
        checkOutput("idleEndValid", 32'(vO),    0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("idleBothBusy",  32'(busyO), 1);
        checkOutput("idleBothValid", 32'(vO),    0);
        idleCycles(1);
        checkOutput("idleBothStillNone", 32'(vO), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("idleBothSample",  32'(vO),       1);
        checkOutput("idleBothLatency", 32'(latencyO), 2);
        checkOutput("idleBothBucket",  32'(bucketO),  expB2);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-interval with one buffered sample
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("preResetValid", 32'(vO),    1);
        checkOutput("preResetBusy",  32'(busyO), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncResetValid",   32'(vO),         0);
        checkOutput("asyncResetBusy",    32'(busyO),      0);
        checkOutput("asyncResetDrops",   32'(dropCountO), 0);
        checkOutput("asyncResetLatency", 32'(latencyO),   0);
        @(negedge clock);
        reset = 1'b0;
        idleCycles(3);
        checkOutput("postResetValid", 32'(vO),    0);
        checkOutput("postResetBusy",  32'(busyO), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("postResetEndIgnored", 32'(vO), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
